// File: rtl/qif_neuron_scheduler.sv
// qif_neuron_scheduler: four quadratic integrate-and-fire neurons that share one
// update datapath. Each tick runs one sweep (LOAD/CALC/WB per neuron), then
// publishes the spike vector.
module qif_neuron_scheduler #(
   parameter logic signed [7:0] V_RESET = -8'sd20,
   parameter logic signed [7:0] V_TH    = 8'sd50
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       tick,
   input  logic       cfg_we,
   input  logic [1:0] cfg_addr,
   input  logic [7:0] cfg_data,
   output logic       busy,
   output logic [7:0] vmem_out,
   output logic [1:0] vmem_idx,
   output logic [3:0] spike,
   output logic       spike_valid,
   output logic       overrun
);

   localparam int unsigned N  = 4;
   localparam int unsigned DW = 8;
   localparam int unsigned IW = 2;
   localparam int unsigned SW = 12;

   localparam logic signed [SW-1:0] SUM_MAX = 12'sd127;
   localparam logic signed [SW-1:0] SUM_MIN = -12'sd128;
   localparam logic signed [DW-1:0] V_MAX   = 8'sh7F;
   localparam logic signed [DW-1:0] V_MIN   = 8'sh80;
   localparam logic [IW-1:0]        IDX_LAST = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_CALC = 3'd2,
      S_WB   = 3'd3,
      S_DONE = 3'd4
   } state_e;

   state_e                    state_q, state_d;
   logic [IW-1:0]             idx_q, idx_d;
   logic [N-1:0][DW-1:0]      v_q, v_d;
   logic [N-1:0][DW-1:0]      i_q, i_d;
   logic signed [DW-1:0]      opv_q, opv_d;
   logic signed [DW-1:0]      opi_q, opi_d;
   logic signed [DW-1:0]      res_q, res_d;
   logic                      res_spk_q, res_spk_d;
   logic [N-1:0]              shadow_q, shadow_d;
   logic [N-1:0]              spike_q, spike_d;
   logic                      spike_valid_q, spike_valid_d;
   logic [DW-1:0]             vmem_q, vmem_d;
   logic [IW-1:0]             vidx_q, vidx_d;
   logic                      overrun_q, overrun_d;
   logic                      busy_q, busy_d;

   logic signed [SW-1:0]      q_c, sq_c, sum_c;
   logic signed [DW-1:0]      sat_c;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; ena low holds every non-idle state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (tick && ena) state_d = S_LOAD;
         S_LOAD: if (ena) state_d = S_CALC;
         S_CALC: if (ena) state_d = S_WB;
         S_WB:   if (ena) state_d = (idx_q == IDX_LAST) ? S_DONE : S_LOAD;
         S_DONE: if (ena) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Shared QIF arithmetic: V + (V>>>3)^2 + (I>>>2), saturated to 8 bits
   always_comb begin
      q_c   = SW'(opv_q >>> 3);
      sq_c  = q_c * q_c;
      sum_c = SW'(opv_q) + sq_c + SW'(opi_q >>> 2);
      if (sum_c > SUM_MAX)      sat_c = V_MAX;
      else if (sum_c < SUM_MIN) sat_c = V_MIN;
      else                      sat_c = DW'(sum_c);
   end

   // Datapath and output next values per state
   always_comb begin
      idx_d         = idx_q;
      v_d           = v_q;
      i_d           = i_q;
      opv_d         = opv_q;
      opi_d         = opi_q;
      res_d         = res_q;
      res_spk_d     = res_spk_q;
      shadow_d      = shadow_q;
      spike_d       = spike_q;
      spike_valid_d = 1'b0;
      vmem_d        = vmem_q;
      vidx_d        = vidx_q;
      overrun_d     = overrun_q;

      if (cfg_we) i_d[cfg_addr] = cfg_data;
      if (tick && (state_q != S_IDLE)) overrun_d = 1'b1;

      unique case (state_q)
         S_IDLE: if (tick && ena) idx_d = '0;
         S_LOAD: if (ena) begin
            opv_d = v_q[idx_q];
            opi_d = i_q[idx_q];
         end
         S_CALC: if (ena) begin
            res_spk_d = (opv_q >= V_TH);
            res_d     = (opv_q >= V_TH) ? V_RESET : sat_c;
         end
         S_WB: if (ena) begin
            v_d[idx_q]      = res_q;
            shadow_d[idx_q] = res_spk_q;
            vmem_d          = res_q;
            vidx_d          = idx_q;
            if (idx_q != IDX_LAST) idx_d = idx_q + IW'(1);
         end
         S_DONE: if (ena) begin
            spike_d       = shadow_q;
            spike_valid_d = 1'b1;
            shadow_d      = '0;
         end
         default: ;
      endcase

      // busy also covers the publish cycle right after DONE
      busy_d = (state_d != S_IDLE) || (state_q == S_DONE);
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q         <= '0;
         v_q           <= {N{V_RESET}};
         i_q           <= '0;
         opv_q         <= '0;
         opi_q         <= '0;
         res_q         <= '0;
         res_spk_q     <= 1'b0;
         shadow_q      <= '0;
         spike_q       <= '0;
         spike_valid_q <= 1'b0;
         vmem_q        <= '0;
         vidx_q        <= '0;
         overrun_q     <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         idx_q         <= idx_d;
         v_q           <= v_d;
         i_q           <= i_d;
         opv_q         <= opv_d;
         opi_q         <= opi_d;
         res_q         <= res_d;
         res_spk_q     <= res_spk_d;
         shadow_q      <= shadow_d;
         spike_q       <= spike_d;
         spike_valid_q <= spike_valid_d;
         vmem_q        <= vmem_d;
         vidx_q        <= vidx_d;
         overrun_q     <= overrun_d;
         busy_q        <= busy_d;
      end
   end

   assign busy        = busy_q;
   assign vmem_out    = vmem_q;
   assign vmem_idx    = vidx_q;
   assign spike       = spike_q;
   assign spike_valid = spike_valid_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_qif_neuron_scheduler.sv
// Scoreboard bench for qif_neuron_scheduler: two instances (V_TH 50 and 127)
// share stimulus; a reference model predicts every write-back and spike vector.
module tb_qif_neuron_scheduler;

   logic       clk = 1'b0;
   logic       rst_n, ena, tick, cfg_we;
   logic [1:0] cfg_addr;
   logic [7:0] cfg_data;

   logic       busy0, busy1, sv0, sv1, ovr0, ovr1;
   logic [7:0] vm0, vm1;
   logic [1:0] vi0, vi1;
   logic [3:0] sp0, sp1;

   always #5 clk = ~clk;

   qif_neuron_scheduler u_dut0 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .tick(tick), .cfg_we(cfg_we),
      .cfg_addr(cfg_addr), .cfg_data(cfg_data), .busy(busy0), .vmem_out(vm0),
      .vmem_idx(vi0), .spike(sp0), .spike_valid(sv0), .overrun(ovr0)
   );

   qif_neuron_scheduler #(.V_RESET(-8'sd20), .V_TH(8'sd127)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .tick(tick), .cfg_we(cfg_we),
      .cfg_addr(cfg_addr), .cfg_data(cfg_data), .busy(busy1), .vmem_out(vm1),
      .vmem_idx(vi1), .spike(sp1), .spike_valid(sv1), .overrun(ovr1)
   );

   typedef struct {int idx; int v0; int v1;} wb_t;
   typedef struct {int s0; int s1;} sp_t;

   wb_t wb_q[$];
   sp_t sp_q[$];
   int  mv0[4], mv1[4], mi[4];
   bit  ovr_exp;
   int  checks = 0;
   int  errors = 0;

   bit  sweeping = 1'b0;
   bit  prev_busy = 1'b0;
   bit  chk_busy_low = 1'b0;
   int  cnt = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // floor division for positive divisor
   function automatic int fdiv(input int a, input int b);
      int q;
      q = a / b;
      if ((a % b != 0) && (a < 0)) q = q - 1;
      return q;
   endfunction

   function automatic int step(input int v, input int i, input int th, output bit sp);
      int s;
      sp = (v >= th);
      if (sp) return -20;
      s = v + fdiv(v, 8) * fdiv(v, 8) + fdiv(i, 4);
      if (s > 127)  s = 127;
      if (s < -128) s = -128;
      return s;
   endfunction

   task automatic model_sweep();
      sp_t e;
      wb_t w;
      bit  b;
      e.s0 = 0;
      e.s1 = 0;
      for (int i = 0; i < 4; i++) begin
         w.idx  = i;
         mv0[i] = step(mv0[i], mi[i], 50, b);
         if (b) e.s0 = e.s0 | (1 << i);
         mv1[i] = step(mv1[i], mi[i], 127, b);
         if (b) e.s1 = e.s1 | (1 << i);
         w.v0 = mv0[i];
         w.v1 = mv1[i];
         wb_q.push_back(w);
      end
      sp_q.push_back(e);
   endtask

   // Monitor: enabled cycles since sweep start locate write-backs (3,6,9,12) and publish (13)
   always @(negedge clk) begin : monitor
      wb_t w;
      sp_t s;
      if (!rst_n) begin
         sweeping     = 1'b0;
         prev_busy    = 1'b0;
         chk_busy_low = 1'b0;
      end else begin
         if (chk_busy_low) begin
            check("busy_after_sweep0", busy0, 0);
            check("busy_after_sweep1", busy1, 0);
            chk_busy_low = 1'b0;
         end
         if (sweeping && ena) begin
            cnt++;
            if ((cnt % 3 == 0) && (cnt <= 12)) begin
               if (wb_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL wb_queue_empty actual=empty required=entry");
               end else begin
                  w = wb_q.pop_front();
                  check("vmem_idx0", vi0, w.idx);
                  check("vmem_out0", int'($signed(vm0)), w.v0);
                  check("vmem_idx1", vi1, w.idx);
                  check("vmem_out1", int'($signed(vm1)), w.v1);
               end
            end
         end
         if (sweeping && cnt == 13) begin
            check("spike_valid0", sv0, 1);
            check("spike_valid1", sv1, 1);
            if (sp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL spike_queue_empty actual=empty required=entry");
            end else begin
               s = sp_q.pop_front();
               check("spike0", sp0, s.s0);
               check("spike1", sp1, s.s1);
            end
            sweeping     = 1'b0;
            chk_busy_low = 1'b1;
         end else begin
            check("spike_valid_quiet0", sv0, 0);
            check("spike_valid_quiet1", sv1, 0);
         end
         check("overrun0", ovr0, int'(ovr_exp));
         check("overrun1", ovr1, int'(ovr_exp));
         if (!sweeping && busy0 && !prev_busy) begin
            sweeping = 1'b1;
            cnt      = 0;
         end
         prev_busy = busy0;
      end
   end

   task automatic do_reset();
      @(negedge clk); #1;
      rst_n = 1'b0;
      wb_q.delete();
      sp_q.delete();
      for (int i = 0; i < 4; i++) begin
         mv0[i] = -20; mv1[i] = -20; mi[i] = 0;
      end
      ovr_exp = 1'b0;
      @(negedge clk);
      check("rst_busy", busy0, 0);
      check("rst_vmem_out", vm0, 0);
      check("rst_vmem_idx", vi0, 0);
      check("rst_spike", sp0, 0);
      check("rst_spike_valid", sv0, 0);
      check("rst_overrun", ovr0, 0);
      check("rst_busy1", busy1, 0);
      #1 rst_n = 1'b1;
   endtask

   task automatic do_cfg(input int a, input int d);
      logic [7:0] dv;
      dv = 8'(d);
      @(negedge clk); #1;
      cfg_we   = 1'b1;
      cfg_addr = 2'(a);
      cfg_data = dv;
      mi[a]    = int'($signed(dv));
      @(negedge clk); #1;
      cfg_we = 1'b0;
   endtask

   task automatic do_tick();
      @(negedge clk); #1;
      tick = 1'b1;
      if (busy0) ovr_exp = 1'b1;
      else if (ena) model_sweep();
      @(negedge clk); #1;
      tick = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((busy0 || busy1 || sweeping) && n < 200);
      if (n >= 200) begin
         checks++; errors++;
         $display("FAIL sweep_timeout actual=busy required=idle");
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; ena = 1'b1; tick = 1'b0; cfg_we = 1'b0;
      cfg_addr = '0; cfg_data = '0;
      for (int i = 0; i < 4; i++) begin
         mv0[i] = -20; mv1[i] = -20; mi[i] = 0;
      end
      ovr_exp = 1'b0;

      // default currents: every neuron goes to -11
      do_reset();
      do_tick(); wait_idle();

      // I[2]=100 only changes neuron 2
      do_reset();
      do_cfg(2, 100);
      do_tick(); wait_idle();

      // strong drive on neuron 0: spike at V_TH=50, saturation at V_TH=127
      do_reset();
      do_cfg(0, 127);
      repeat (5) begin do_tick(); wait_idle(); end

      // tick mid-sweep is dropped and flags overrun
      do_tick();
      repeat (4) @(negedge clk);
      do_tick();
      wait_idle();
      check("overrun_sticky", ovr0, 1);

      // reset mid-sweep aborts without publishing
      do_tick();
      repeat (5) @(negedge clk);
      do_reset();
      check("abort_busy", busy0, 0);
      check("abort_overrun", ovr0, 0);
      do_tick(); wait_idle();

      // freeze for 10 cycles mid-sweep
      do_tick();
      repeat (4) @(negedge clk);
      #1 ena = 1'b0;
      repeat (10) begin
         @(negedge clk);
         check("busy_frozen", busy0, 1);
         check("spike_valid_frozen", sv0, 0);
      end
      #1 ena = 1'b1;
      wait_idle();

      // randomized sweeps with config, stalls and overrun ticks
      repeat (30) begin
         if ($urandom_range(0, 1) == 1) do_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
         do_tick();
         repeat ($urandom_range(0, 6)) begin
            @(negedge clk); #1;
            ena = ($urandom_range(0, 3) != 0);
         end
         if ($urandom_range(0, 3) == 0) do_tick();
         @(negedge clk); #1 ena = 1'b1;
         wait_idle();
      end

      check("wb_queue_drained", wb_q.size(), 0);
      check("spike_queue_drained", sp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
